// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg
//   Shared definitions for the count-enable controller slice:
//   FSM state encoding and default widths of the burst-length and
//   prescale datapaths.
package count_ctrl_pkg;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned PRE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_enable_ctrl_if.sv
// count_enable_ctrl_if
//   Request/status bundle between a burst requester (master) and the
//   count-enable controller (slave).
//     start     : burst request, sampled on clk
//     stop      : abort request, sampled on clk
//     burst_len : enable pulses per burst, latched at start
//     prescale  : idle cycles between pulses, latched at start
//     enable    : registered count-enable for the downstream counter
//     busy      : registered, high while a burst is in progress
//     done      : registered one-cycle completion pulse
interface count_enable_ctrl_if
    import count_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
);
    logic             start;
    logic             stop;
    logic [LEN_W-1:0] burst_len;
    logic [PRE_W-1:0] prescale;
    logic             enable;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, burst_len, prescale,
        input  enable, busy, done
    );

    modport slave (
        input  start, stop, burst_len, prescale,
        output enable, busy, done
    );
endinterface

// File: rtl/enable_prescaler.sv
// enable_prescaler
//   Free-running prescale counter. tick is high whenever the count equals
//   pre_q; clr returns the count to zero on the next edge.
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset
//     clr   : synchronous clear of the count
//     pre_q : latched prescale value
//     tick  : count has reached pre_q (combinational)
module enable_prescaler
    import count_ctrl_pkg::*;
#(
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PRE_W-1:0] pre_q,
    output logic             tick
);
    logic [PRE_W-1:0] pre_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = (pre_cnt == pre_q);
endmodule

// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl
//   Issues a burst of burst_len registered enable pulses to a downstream
//   counter, spaced prescale+1 cycles apart, then a one-cycle done pulse.
//   stop aborts a running burst without done; reset aborts immediately.
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : count_enable_ctrl_if slave (start, stop, burst_len,
//             prescale in; enable, busy, done out)
//   Build option: COUNT_ENABLE_PRESCALE_EN includes the prescaler. Without
//   it the prescale input is ignored and pulses are on consecutive cycles.
module count_enable_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    count_enable_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tick;

    // A zero-length request is not a burst at all.
    assign accept = bus.start && (bus.burst_len != '0);

`ifdef COUNT_ENABLE_PRESCALE_EN
    logic [PRE_W-1:0] pre_q;
    logic             clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (state_q == IDLE && accept) begin
            pre_q <= bus.prescale;
        end
    end

    // Held at zero outside RUN so every burst starts from a fresh count.
    assign clr = (state_q != RUN) || tick || bus.stop;

    enable_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .pre_q (pre_q),
        .tick  (tick)
    );
`else
    logic [PRE_W-1:0] unused_prescale;
    assign unused_prescale = bus.prescale;
    assign tick            = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    rem_d   = bus.burst_len;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // stop outranks a pulse due on the same edge, including the last.
                if (bus.stop) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    busy_d = 1'b1;
                    if (tick) begin
                        enable_d = 1'b1;
                        rem_d    = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: doc/count_enable_ctrl.md
COUNT_ENABLE_CTRL -- requirements
Module: count_enable_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, the width of the burst-length register and remaining-pulse counter.
REQ-002 The block SHALL have parameter PRE_W, default 8, the width of the prescale register and prescale counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, burst request, sampled on clk.
REQ-006 The block SHALL have port stop, input, 1 bit, abort request, sampled on clk.
REQ-007 The block SHALL have port burst_len, input, LEN_W bits, number of enable pulses per burst, latched at start.
REQ-008 The block SHALL have port prescale, input, PRE_W bits, idle cycles between pulses, latched at start.
REQ-009 The block SHALL have port enable, output, 1 bit, registered count-enable driven into the downstream counter's enable input.
REQ-010 The block SHALL have port busy, output, 1 bit, registered, high while a burst is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, registered one-cycle completion pulse.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, start=1 with burst_len!=0 SHALL, at that edge, latch burst_len into rem and prescale into pre_q, clear pre_cnt and enter RUN; busy SHALL go high at that edge.
REQ-014 In IDLE, start=1 with burst_len=0 SHALL be ignored: no state change and no done.
REQ-015 In RUN, each edge with pre_cnt==pre_q SHALL set enable=1, clear pre_cnt and decrement rem; otherwise enable=0 and pre_cnt increments.
REQ-016 The first enable cycle SHALL begin at the (pre_q+1)th edge after the start edge; consecutive pulses SHALL be pre_q+1 cycles apart.
REQ-017 With pre_q=0, enable SHALL be high for exactly burst_len consecutive cycles.
REQ-018 The edge issuing the pulse with rem==1 SHALL move to DONE.
REQ-019 In DONE, enable=0, busy=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-020 start asserted in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-021 stop=1 in RUN SHALL, at that edge, force IDLE, enable=0 and busy=0, and SHALL NOT produce done.
REQ-022 stop and the final pulse on the same edge SHALL resolve with stop winning: no enable pulse and no done.
REQ-023 Changes on burst_len or prescale during RUN SHALL have no effect.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, enable=0, busy=0, done=0, rem=0, pre_cnt=0, pre_q=0, independent of clk.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release, the block SHALL require a new start.

Configuration
REQ-026 Macro COUNT_ENABLE_PRESCALE_EN defined SHALL include the prescaler as specified above.
REQ-027 Without COUNT_ENABLE_PRESCALE_EN, the prescale port SHALL remain but be ignored, pre_q SHALL be treated as 0, and no prescale counter SHALL be built.

Structure
REQ-028 Shared package count_ctrl_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default LEN_W/PRE_W constants.
REQ-029 The prescale counter SHALL be the sub-module enable_prescaler (inputs clk, reset, clr, pre_q; output tick), instantiated only under COUNT_ENABLE_PRESCALE_EN.

Verification
REQ-030 Scenario: reset, then start with burst_len=5 and prescale=0 -> enable high for 5 consecutive cycles starting 1 cycle after the start edge, done high for 1 cycle after the last pulse, busy low.
REQ-031 Scenario: burst_len=3, prescale=2 -> enable pulses at edges 3, 6 and 9 after start; done pulse in cycle 10; downstream 4-bit count advances by exactly 3.
REQ-032 Scenario: burst_len=20, prescale=0 driving the 4-bit downstream counter -> count wraps 15 to 0 and ends at 4; done pulse occurs once.
REQ-033 Scenario: stop after the 2nd of 8 pulses -> enable low from the next cycle, busy=0, no done; a new start then runs a full burst.
REQ-034 Scenario: start with burst_len=0, and start re-asserted during RUN -> both ignored; pulse count unchanged.
REQ-035 Scenario: reset asserted asynchronously mid-burst (between clk edges) -> enable, busy and done all 0 immediately; build without COUNT_ENABLE_PRESCALE_EN and prescale=7 -> pulses on consecutive cycles.
